// File: rtl/layer_buf_pkg.sv
// Shared types and helpers for the layer buffer: pooling mode codes,
// the pooling FSM state type and the signed saturation helper.
package layer_buf_pkg;

  localparam int POOL_MAX = 0;
  localparam int POOL_AVG = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_WR,
    S_DONE
  } pool_state_t;

  // Clamp a sign-extended sum into the signed range of a dw-bit word.
  function automatic logic signed [31:0] sat(input logic signed [32:0] x, input int dw);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (dw - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (dw - 1));
    if (x > hi)      return 32'(hi);
    else if (x < lo) return 32'(lo);
    else             return 32'(x);
  endfunction

endpackage

// File: rtl/layer_buf_ram.sv
// One channel of feature-map storage: a synchronous read/write port A used
// by stores and pooling, plus two synchronous read ports feeding data_out.
module layer_buf_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 784,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout_a,
  input  logic          re,
  input  logic [AW-1:0] addr_b,
  input  logic [AW-1:0] addr_c,
  output logic [DW-1:0] dout_b,
  output logic [DW-1:0] dout_c
);

  logic [DW-1:0] mem [DEPTH];

  // Port A: write-first-free read/write used by the store path and the pooler.
  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    dout_a <= mem[addr_a];
  end

  // Read ports B/C: registered outputs that clear on reset and hold while re is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_b <= '0;
      dout_c <= '0;
    end else if (re) begin
      dout_b <= mem[addr_b];
      dout_c <= mem[addr_c];
    end
  end

endmodule

// File: rtl/layer_buf.sv
// Multi-channel activation buffer with saturating bias-add stores, dual
// read ports and an in-place 2x2 pooling engine shared by all channels.
module layer_buf
  import layer_buf_pkg::*;
#(
  parameter int DW        = 8,
  parameter int NCH       = 8,
  parameter int W         = 28,
  parameter int H         = 28,
  parameter int AW        = $clog2(W * H),
  parameter int POOL_MODE = 0,
  parameter int RELU      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   store,
  input  logic [$clog2(NCH)-1:0] st_ch,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          value,
  input  logic [DW-1:0]          bias,
  input  logic                   load,
  input  logic [AW-1:0]          rd_addr1,
  input  logic [AW-1:0]          rd_addr2,
  output logic [NCH*2*DW-1:0]    data_out,
  input  logic                   pool_start,
  output logic                   pool_busy,
  output logic                   pool_done,
  output logic                   st_err
);

  localparam int CW = $clog2(NCH);
  localparam logic [CW:0] NCH_L   = (CW + 1)'(NCH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(W * H);

  pool_state_t   state;
  logic [AW-1:0] r;
  logic [AW-1:0] c;

  // Store path: add at DW+1 bits, saturate, then optional ReLU.
  logic signed [DW-1:0] value_s;
  logic signed [DW-1:0] bias_s;
  logic signed [DW:0]   st_sum;
  logic signed [DW-1:0] st_sat;
  logic signed [DW-1:0] st_val;
  logic                 st_ok;

  assign value_s = value;
  assign bias_s  = bias;
  assign st_sum  = (DW + 1)'(value_s) + (DW + 1)'(bias_s);
  assign st_sat  = DW'(sat(33'(st_sum), DW));
  assign st_val  = (RELU != 0 && st_sat < 0) ? '0 : st_sat;
  assign st_ok   = store && !pool_busy && ({1'b0, st_ch} < NCH_L) && ({1'b0, st_addr} < DEPTH_L);

  // Pooling addresses: window element picked by the RD state, result goes to the compact index.
  logic          rd_row;
  logic          rd_col;
  logic          reading;
  logic          last_win;
  logic [AW-1:0] pool_rd_addr;
  logic [AW-1:0] pool_wr_addr;
  logic [AW-1:0] addr_a;

  // Decode which of the four window elements this RD state fetches.
  always_comb begin
    rd_row = (state == S_RD2) || (state == S_RD3);
    rd_col = (state == S_RD1) || (state == S_RD3);
  end

  assign reading      = (state == S_RD0) || (state == S_RD1) || (state == S_RD2) || (state == S_RD3);
  assign pool_rd_addr = AW'((2 * int'(r) + int'(rd_row)) * W + 2 * int'(c) + int'(rd_col));
  assign pool_wr_addr = AW'(int'(r) * (W / 2) + int'(c));
  assign addr_a       = reading ? pool_rd_addr : ((state == S_WR) ? pool_wr_addr : st_addr);
  assign last_win     = (r == AW'(H / 2 - 1)) && (c == AW'(W / 2 - 1));

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [DW-1:0]        dout_a;
    logic [DW-1:0]        dout_b;
    logic [DW-1:0]        dout_c;
    logic [DW-1:0]        wdata;
    logic [DW-1:0]        pool_res;
    logic                 we;
    logic signed [DW-1:0] d_s;
    logic signed [DW+1:0] d_x;
    logic signed [DW+1:0] acc;
    logic signed [DW+1:0] comb_v;

    assign d_s = dout_a;
    assign d_x = (DW + 2)'(d_s);

    // Fold the incoming window datum into the running max or sum.
    always_comb begin
      if (POOL_MODE == POOL_AVG) comb_v = acc + d_x;
      else                       comb_v = (d_x > acc) ? d_x : acc;
    end

    // Accumulate the first three window data; the fourth is folded combinationally in WR.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   acc <= '0;
      else if (state == S_RD1)                    acc <= d_x;
      else if (state == S_RD2 || state == S_RD3)  acc <= comb_v;
    end

    assign pool_res = (POOL_MODE == POOL_AVG) ? DW'(comb_v >>> 2) : DW'(comb_v);
    assign we       = (state == S_WR) || (st_ok && st_ch == CW'(ch));
    assign wdata    = (state == S_WR) ? pool_res : st_val;

    layer_buf_ram #(.DW(DW), .DEPTH(W * H), .AW(AW)) u_ram (
      .clk    (clk),
      .rst    (rst),
      .we_a   (we),
      .addr_a (addr_a),
      .din_a  (wdata),
      .dout_a (dout_a),
      .re     (load),
      .addr_b (rd_addr1),
      .addr_c (rd_addr2),
      .dout_b (dout_b),
      .dout_c (dout_c)
    );

    assign data_out[(2 * ch) * DW +: DW]     = dout_b;
    assign data_out[(2 * ch + 1) * DW +: DW] = dout_c;
  end

  // Pooling FSM with registered busy/done flags and the sticky store-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      r         <= '0;
      c         <= '0;
      pool_busy <= 1'b0;
      pool_done <= 1'b0;
      st_err    <= 1'b0;
    end else begin
      // NOTE: default first so pool_done is a single-cycle pulse without per-state clears.
      pool_done <= 1'b0;
      if (store && pool_busy) st_err <= 1'b1;
      case (state)
        S_IDLE: if (pool_start) begin
          state     <= S_RD0;
          pool_busy <= 1'b1;
        end
        S_RD0: state <= S_RD1;
        S_RD1: state <= S_RD2;
        S_RD2: state <= S_RD3;
        S_RD3: state <= S_WR;
        S_WR: begin
          if (last_win) begin
            state     <= S_DONE;
            pool_busy <= 1'b0;
            pool_done <= 1'b1;
            r         <= '0;
            c         <= '0;
          end else begin
            state <= S_RD0;
            if (c == AW'(W / 2 - 1)) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_buf.sv
// Directed bench: three 4x4 instances (max pool, avg pool, ReLU with 6 channels)
// share stimulus; each scenario task checks its own hand-computed results.
module tb_layer_buf;

  logic         clk;
  logic         rst;
  logic         store;
  logic [2:0]   st_ch;
  logic [4:0]   st_addr;
  logic [7:0]   value;
  logic [7:0]   bias;
  logic         load;
  logic [4:0]   rd_addr1;
  logic [4:0]   rd_addr2;
  logic         pool_start;

  logic [127:0] dout_max;
  logic [127:0] dout_avg;
  logic [95:0]  dout_rel;
  logic         busy_max, busy_avg, busy_rel;
  logic         done_max, done_avg, done_rel;
  logic         err_max, err_avg, err_rel;

  int pass_cnt  = 0;
  int total_cnt = 0;

  layer_buf #(.DW(8), .NCH(8), .W(4), .H(4), .AW(5), .POOL_MODE(0), .RELU(0)) u_max (
    .clk(clk), .rst(rst), .store(store), .st_ch(st_ch), .st_addr(st_addr),
    .value(value), .bias(bias), .load(load), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .data_out(dout_max), .pool_start(pool_start), .pool_busy(busy_max),
    .pool_done(done_max), .st_err(err_max)
  );

  layer_buf #(.DW(8), .NCH(8), .W(4), .H(4), .AW(5), .POOL_MODE(1), .RELU(0)) u_avg (
    .clk(clk), .rst(rst), .store(store), .st_ch(st_ch), .st_addr(st_addr),
    .value(value), .bias(bias), .load(load), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .data_out(dout_avg), .pool_start(pool_start), .pool_busy(busy_avg),
    .pool_done(done_avg), .st_err(err_avg)
  );

  layer_buf #(.DW(8), .NCH(6), .W(4), .H(4), .AW(5), .POOL_MODE(0), .RELU(1)) u_rel (
    .clk(clk), .rst(rst), .store(store), .st_ch(st_ch), .st_addr(st_addr),
    .value(value), .bias(bias), .load(load), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .data_out(dout_rel), .pool_start(pool_start), .pool_busy(busy_rel),
    .pool_done(done_rel), .st_err(err_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane(input logic [127:0] v, input int ch, input int p);
    return v[(2 * ch + p) * 8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int ch, input int addr, input int v, input int b);
    store   = 1'b1;
    st_ch   = 3'(ch);
    st_addr = 5'(addr);
    value   = 8'(v);
    bias    = 8'(b);
    tick();
    store = 1'b0;
  endtask

  task automatic do_load(input int a1, input int a2);
    load     = 1'b1;
    rd_addr1 = 5'(a1);
    rd_addr2 = 5'(a2);
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #23;
    total_cnt++;
    if ({busy_max, done_max, err_max} !== 3'b000)
      $display("FAIL reset_flags_max got %b exp 000", {busy_max, done_max, err_max});
    else pass_cnt++;
    total_cnt++;
    if ({busy_avg, done_avg, err_avg, busy_rel, done_rel, err_rel} !== 6'b0)
      $display("FAIL reset_flags_other got %b exp 000000",
               {busy_avg, done_avg, err_avg, busy_rel, done_rel, err_rel});
    else pass_cnt++;
    total_cnt++;
    if (dout_max !== '0 || dout_avg !== '0 || dout_rel !== '0)
      $display("FAIL reset_data_out got %h exp 0", dout_max);
    else pass_cnt++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    do_store(0, 0, 100, 50);
    do_load(0, 0);
    total_cnt++;
    if (lane(dout_max, 0, 0) !== 8'd127 || lane(dout_max, 0, 1) !== 8'd127)
      $display("FAIL sat_pos got %0d/%0d exp 127", $signed(lane(dout_max, 0, 0)), $signed(lane(dout_max, 0, 1)));
    else pass_cnt++;

    do_store(0, 0, -100, -50);
    do_load(0, 0);
    total_cnt++;
    if (lane(dout_max, 0, 0) !== 8'h80)
      $display("FAIL sat_neg got %0d exp -128", $signed(lane(dout_max, 0, 0)));
    else pass_cnt++;
    total_cnt++;
    if (lane({32'b0, dout_rel}, 0, 0) !== 8'd0)
      $display("FAIL relu_sat_neg got %0d exp 0", $signed(lane({32'b0, dout_rel}, 0, 0)));
    else pass_cnt++;

    do_store(0, 0, -3, 1);
    do_load(0, 0);
    total_cnt++;
    if (lane({32'b0, dout_rel}, 0, 0) !== 8'd0)
      $display("FAIL relu_small got %0d exp 0", $signed(lane({32'b0, dout_rel}, 0, 0)));
    else pass_cnt++;
    total_cnt++;
    if (lane(dout_max, 0, 0) !== 8'hFE)
      $display("FAIL no_relu_small got %0d exp -2", $signed(lane(dout_max, 0, 0)));
    else pass_cnt++;

    do_store(0, 0, 20, -5);
    do_load(0, 0);
    total_cnt++;
    if (lane(dout_max, 0, 0) !== 8'd15 || lane({32'b0, dout_rel}, 0, 0) !== 8'd15)
      $display("FAIL plain_add got %0d exp 15", $signed(lane(dout_max, 0, 0)));
    else pass_cnt++;
  endtask

  task automatic test_drop();
    do_store(0, 16, 99, 0);
    do_load(0, 0);
    total_cnt++;
    if (lane(dout_max, 0, 0) !== 8'd15)
      $display("FAIL drop_addr got %0d exp 15", $signed(lane(dout_max, 0, 0)));
    else pass_cnt++;
  endtask

  task automatic test_dual_read();
    for (int ch = 0; ch < 8; ch++) begin
      do_store(ch, 5, 10 + ch, 0);
      do_store(ch, 10, -(20 + ch), 0);
    end
    do_load(5, 10);
    for (int ch = 0; ch < 8; ch++) begin
      total_cnt++;
      if (lane(dout_max, ch, 0) !== 8'(10 + ch))
        $display("FAIL dual_p1_ch%0d got %0d exp %0d", ch, $signed(lane(dout_max, ch, 0)), 10 + ch);
      else pass_cnt++;
      total_cnt++;
      if (lane(dout_max, ch, 1) !== 8'(-(20 + ch)))
        $display("FAIL dual_p2_ch%0d got %0d exp %0d", ch, $signed(lane(dout_max, ch, 1)), -(20 + ch));
      else pass_cnt++;
    end
    rd_addr1 = 5'd0;
    tick();
    total_cnt++;
    if (lane(dout_max, 0, 0) !== 8'd10)
      $display("FAIL load_hold got %0d exp 10", $signed(lane(dout_max, 0, 0)));
    else pass_cnt++;
  endtask

  task automatic test_pool();
    int cnt;
    // ch1: rows {1,2,3,4},{5,6,7,8},... with addr5 zeroed until the start cycle
    for (int a = 0; a < 16; a++) do_store(1, a, (a == 5) ? 0 : a + 1, 0);
    // ch2: windows {-1,-2,-3,-4} and {1,1,1,2}, zeros below
    for (int a = 0; a < 16; a++) do_store(2, a, 0, 0);
    do_store(2, 0, -1, 0);
    do_store(2, 1, -2, 0);
    do_store(2, 4, -3, 0);
    do_store(2, 5, -4, 0);
    do_store(2, 2, 1, 0);
    do_store(2, 3, 1, 0);
    do_store(2, 6, 1, 0);
    do_store(2, 7, 2, 0);
    do_store(3, 9, 7, 0);

    // Store of addr5 in the same cycle as pool_start must land before pooling reads it
    store = 1'b1; st_ch = 3'd1; st_addr = 5'd5; value = 8'd6; bias = 8'd0;
    pool_start = 1'b1;
    tick();
    store = 1'b0;
    pool_start = 1'b0;
    cnt = 1;
    while (!done_max && cnt < 60) begin
      if (cnt == 3) begin
        total_cnt++;
        if (busy_max !== 1'b1) $display("FAIL busy_mid got %b exp 1", busy_max);
        else pass_cnt++;
      end
      if (cnt == 8) begin
        store = 1'b1; st_ch = 3'd3; st_addr = 5'd9; value = 8'd55; bias = 8'd0;
        pool_start = 1'b1;
      end
      tick();
      store = 1'b0;
      pool_start = 1'b0;
      cnt++;
    end
    total_cnt++;
    if (cnt != 21) $display("FAIL pool_latency got %0d exp 21", cnt);
    else pass_cnt++;
    total_cnt++;
    if (done_avg !== 1'b1) $display("FAIL avg_done got %b exp 1", done_avg);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done_max, busy_max} !== 2'b00) $display("FAIL done_pulse got %b exp 00", {done_max, busy_max});
    else pass_cnt++;
    total_cnt++;
    if (err_max !== 1'b1) $display("FAIL st_err_set got %b exp 1", err_max);
    else pass_cnt++;

    do_load(0, 1);
    total_cnt++;
    if (lane(dout_max, 1, 0) !== 8'd6 || lane(dout_max, 1, 1) !== 8'd8)
      $display("FAIL max_w01 got %0d,%0d exp 6,8", lane(dout_max, 1, 0), lane(dout_max, 1, 1));
    else pass_cnt++;
    total_cnt++;
    if (lane(dout_avg, 1, 0) !== 8'd3 || lane(dout_avg, 1, 1) !== 8'd5)
      $display("FAIL avg_w01 got %0d,%0d exp 3,5", lane(dout_avg, 1, 0), lane(dout_avg, 1, 1));
    else pass_cnt++;
    total_cnt++;
    if (lane(dout_max, 2, 0) !== 8'hFF || lane(dout_max, 2, 1) !== 8'd2)
      $display("FAIL max_signed got %0d,%0d exp -1,2", $signed(lane(dout_max, 2, 0)), $signed(lane(dout_max, 2, 1)));
    else pass_cnt++;
    total_cnt++;
    if (lane(dout_avg, 2, 0) !== 8'hFD || lane(dout_avg, 2, 1) !== 8'd1)
      $display("FAIL avg_floor got %0d,%0d exp -3,1", $signed(lane(dout_avg, 2, 0)), $signed(lane(dout_avg, 2, 1)));
    else pass_cnt++;

    do_load(2, 3);
    total_cnt++;
    if (lane(dout_max, 1, 0) !== 8'd14 || lane(dout_max, 1, 1) !== 8'd16)
      $display("FAIL max_w23 got %0d,%0d exp 14,16", lane(dout_max, 1, 0), lane(dout_max, 1, 1));
    else pass_cnt++;
    total_cnt++;
    if (lane(dout_avg, 1, 0) !== 8'd11 || lane(dout_avg, 1, 1) !== 8'd13)
      $display("FAIL avg_w23 got %0d,%0d exp 11,13", lane(dout_avg, 1, 0), lane(dout_avg, 1, 1));
    else pass_cnt++;

    do_load(9, 9);
    total_cnt++;
    if (lane(dout_max, 3, 0) !== 8'd7)
      $display("FAIL blocked_store got %0d exp 7", lane(dout_max, 3, 0));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pool();
    logic saw_done;
    for (int a = 0; a < 16; a++) do_store(1, a, a + 1, 0);
    pool_start = 1'b1;
    tick();
    pool_start = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    #2;
    total_cnt++;
    if ({busy_max, done_max, err_max} !== 3'b000)
      $display("FAIL midpool_reset_flags got %b exp 000", {busy_max, done_max, err_max});
    else pass_cnt++;
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_max || busy_max) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done !== 1'b0) $display("FAIL midpool_no_done got %b exp 0", saw_done);
    else pass_cnt++;
    do_load(0, 1);
    total_cnt++;
    if (lane(dout_max, 1, 0) !== 8'd6 || lane(dout_max, 1, 1) !== 8'd2)
      $display("FAIL midpool_partial got %0d,%0d exp 6,2", lane(dout_max, 1, 0), lane(dout_max, 1, 1));
    else pass_cnt++;
  endtask

  initial begin
    store = 1'b0; st_ch = '0; st_addr = '0; value = '0; bias = '0;
    load = 1'b0; rd_addr1 = '0; rd_addr2 = '0; pool_start = 1'b0;
    test_reset();
    test_saturation();
    test_drop();
    test_dual_read();
    test_pool();
    test_reset_mid_pool();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
